// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 4-router ACK link:
//   - packet type encoding carried in the decapsulated header (hdr_type)
//   - router ids ROUTER0..ROUTER3
//   - receive-controller FSM state encoding (also used by the bench)
// -----------------------------------------------------------------------------
package router_pkg;

    // Header type bit
    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_ACK  = 1'b1;

    // Router ids on the 4-router link
    localparam logic [1:0] ROUTER0 = 2'd0;
    localparam logic [1:0] ROUTER1 = 2'd1;
    localparam logic [1:0] ROUTER2 = 2'd2;
    localparam logic [1:0] ROUTER3 = 2'd3;

    // Receive controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK_SN = 2'd1,
        DELIVER  = 2'd2,
        SEND_ACK = 2'd3
    } recv_state_t;

endpackage

// File: rtl/recv_controller_if.sv
// -----------------------------------------------------------------------------
// recv_controller_if
// Handshake bundle around recv_controller.
//   hdr_*            : decapsulated header in (valid/ready)
//   *_ack_pkt_recv   : received ACK handed to send_controller (valid/wait)
//   deliver_*        : local sink delivery (start pulse / done)
//   ack_req_*        : ACK-transmit request (valid/ready)
// Modports: slave = the controller, master = its environment.
// -----------------------------------------------------------------------------
interface recv_controller_if #(
    parameter int DFX_WIDTH     = 2,
    parameter int SEQ_NUM_WIDTH = 1
);
    // Header from decap
    logic                     hdr_valid;
    logic                     hdr_ready;
    logic                     hdr_type;
    logic [DFX_WIDTH-1:0]     hdr_src_dfx;
    logic [DFX_WIDTH-1:0]     hdr_dst_dfx;
    logic [SEQ_NUM_WIDTH-1:0] hdr_seq;

    // Received ACK to the send side
    logic                     valid_ack_pkt_recv;
    logic [SEQ_NUM_WIDTH-1:0] rn_ack_pkt_recv;
    logic [DFX_WIDTH-1:0]     src_dfx_ack_pkt_recv;
    logic                     wait_ack_pkt_recv;

    // Local delivery
    logic                     start_deliver_pkt;
    logic [DFX_WIDTH-1:0]     deliver_src_dfx;
    logic [SEQ_NUM_WIDTH-1:0] deliver_sn;
    logic                     deliver_done;

    // ACK-transmit request
    logic                     ack_req_valid;
    logic                     ack_req_ready;
    logic [DFX_WIDTH-1:0]     ack_req_dst_dfx;
    logic [SEQ_NUM_WIDTH-1:0] ack_req_rn;

    modport slave (
        input  hdr_valid, hdr_type, hdr_src_dfx, hdr_dst_dfx, hdr_seq,
        input  wait_ack_pkt_recv, deliver_done, ack_req_ready,
        output hdr_ready,
        output valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
        output start_deliver_pkt, deliver_src_dfx, deliver_sn,
        output ack_req_valid, ack_req_dst_dfx, ack_req_rn
    );

    modport master (
        output hdr_valid, hdr_type, hdr_src_dfx, hdr_dst_dfx, hdr_seq,
        output wait_ack_pkt_recv, deliver_done, ack_req_ready,
        input  hdr_ready,
        input  valid_ack_pkt_recv, rn_ack_pkt_recv, src_dfx_ack_pkt_recv,
        input  start_deliver_pkt, deliver_src_dfx, deliver_sn,
        input  ack_req_valid, ack_req_dst_dfx, ack_req_rn
    );

endinterface

// File: rtl/recv_controller_seq_table.sv
// -----------------------------------------------------------------------------
// seq_table
// Per-source expected receive number (rn_expect). 2^IDX_WIDTH entries of
// DATA_WIDTH bits, wrapping modulo 2^DATA_WIDTH.
//   clk, rst : clock, asynchronous active-high reset (all entries to 0)
//   rd_idx   : combinational read index -> rd_data
//   inc_en   : increment entry inc_idx on the rising edge
// -----------------------------------------------------------------------------
module seq_table #(
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  inc_en,
    input  logic [IDX_WIDTH-1:0]  inc_idx
);
    localparam int NUM = 2 ** IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [NUM];

    // NOTE: this array is reset because a restarted link must expect sn 0
    // from every source; a storage array with no such need is left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (inc_en) begin
            mem[inc_idx] <= mem[inc_idx] + DATA_WIDTH'(1);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/recv_controller.sv
// -----------------------------------------------------------------------------
// recv_controller
// Receive side of the ACK link. Accepts decapsulated headers, buffers received
// ACKs for send_controller, checks DATA sequence numbers per source, delivers
// in-order DATA to the local sink and requests an ACK carrying the updated rn
// for every DATA packet addressed to this router.
//   clk, rst     : clock, asynchronous active-high reset
//   my_dfx       : this router's id (static)
//   bus          : recv_controller_if.slave handshake bundle
//   dup_cnt      : saturating count of duplicate DATA packets
//   misroute_cnt : saturating count of headers not addressed to my_dfx
// -----------------------------------------------------------------------------
module recv_controller
    import router_pkg::*;
#(
    parameter int DFX_WIDTH     = 2,
    parameter int SEQ_NUM_WIDTH = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DFX_WIDTH-1:0] my_dfx,
    recv_controller_if.slave     bus,
    output logic [CNT_WIDTH-1:0] dup_cnt,
    output logic [CNT_WIDTH-1:0] misroute_cnt
);
    recv_state_t state_q, state_d;

    logic [DFX_WIDTH-1:0]     src_q;
    logic [SEQ_NUM_WIDTH-1:0] sn_q;
    logic                     ack_full_q;
    logic [SEQ_NUM_WIDTH-1:0] ack_rn_q;
    logic [DFX_WIDTH-1:0]     ack_src_q;
    logic                     start_q;
    logic [SEQ_NUM_WIDTH-1:0] rn_cur;

    logic hdr_ready;
    logic hdr_fire;
    logic for_me;
    logic data_fire;
    logic ack_fire;
    logic sn_match;
    logic deliver_fire;

    // A held ACK blocks every header, so the buffer can never be overwritten.
    assign hdr_ready    = (state_q == IDLE) && !ack_full_q;
    assign hdr_fire     = bus.hdr_valid && hdr_ready;
    assign for_me       = (bus.hdr_dst_dfx == my_dfx);
    assign data_fire    = hdr_fire && for_me && (bus.hdr_type == PKT_DATA);
    assign ack_fire     = hdr_fire && for_me && (bus.hdr_type == PKT_ACK);
    assign sn_match     = (sn_q == rn_cur);
    assign deliver_fire = (state_q == DELIVER) && bus.deliver_done;

    // rn_cur is read by the registered source, so in SEND_ACK it already
    // reflects the increment made on the deliver_done edge.
    seq_table #(
        .IDX_WIDTH  (DFX_WIDTH),
        .DATA_WIDTH (SEQ_NUM_WIDTH)
    ) u_seq_table (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (src_q),
        .rd_data (rn_cur),
        .inc_en  (deliver_fire),
        .inc_idx (src_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (data_fire)         state_d = CHECK_SN;
            CHECK_SN: state_d = sn_match ? DELIVER : SEND_ACK;
            DELIVER:  if (bus.deliver_done)  state_d = SEND_ACK;
            SEND_ACK: if (bus.ack_req_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q        <= '0;
            sn_q         <= '0;
            start_q      <= 1'b0;
            ack_full_q   <= 1'b0;
            ack_rn_q     <= '0;
            ack_src_q    <= '0;
            dup_cnt      <= '0;
            misroute_cnt <= '0;
        end else begin
            if (data_fire) begin
                src_q <= bus.hdr_src_dfx;
                sn_q  <= bus.hdr_seq;
            end

            // High only in the first DELIVER cycle: set on the CHECK_SN exit.
            start_q <= (state_q == CHECK_SN) && sn_match;

            if (ack_fire) begin
                ack_full_q <= 1'b1;
                ack_rn_q   <= bus.hdr_seq;
                ack_src_q  <= bus.hdr_src_dfx;
            end else if (ack_full_q && bus.wait_ack_pkt_recv) begin
                ack_full_q <= 1'b0;
            end

            if (hdr_fire && !for_me && (misroute_cnt != '1)) begin
                misroute_cnt <= misroute_cnt + CNT_WIDTH'(1);
            end

            if ((state_q == CHECK_SN) && !sn_match && (dup_cnt != '1)) begin
                dup_cnt <= dup_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.hdr_ready            = hdr_ready;
    assign bus.valid_ack_pkt_recv   = ack_full_q;
    assign bus.rn_ack_pkt_recv      = ack_rn_q;
    assign bus.src_dfx_ack_pkt_recv = ack_src_q;
    assign bus.start_deliver_pkt    = start_q;
    assign bus.deliver_src_dfx      = src_q;
    assign bus.deliver_sn           = sn_q;
    assign bus.ack_req_valid        = (state_q == SEND_ACK);
    assign bus.ack_req_dst_dfx      = src_q;
    assign bus.ack_req_rn           = rn_cur;

endmodule

// File: doc/recv_controller.md
# recv_controller

Receive-side controller of the 4-router ACK link. It takes decapsulated packet headers, returns ACK packets to `send_controller` through the `valid_ack_pkt_recv`/`wait_ack_pkt_recv` handshake, and checks DATA packets against a per-source expected sequence number. In-order DATA packets go to the local sink; duplicates are discarded. Every DATA packet addressed to this router produces an ACK-transmit request carrying the current receive number (rn).

## Interface
- `DFX_WIDTH`, 2: router id width. Number of routers NR = 2^DFX_WIDTH.
- `SEQ_NUM_WIDTH`, 1: sn/rn width. Arithmetic is modulo 2^SEQ_NUM_WIDTH.
- `CNT_WIDTH`, 8: width of the saturating drop counters.

Ports:
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `my_dfx` in DFX_WIDTH: this router's id. Static.
- `hdr_valid` in 1: header from the decap stage is valid.
- `hdr_ready` out 1: accept. A header transfers when `hdr_valid && hdr_ready`.
- `hdr_type` in 1: 0 = DATA, 1 = ACK.
- `hdr_src_dfx`, `hdr_dst_dfx` in DFX_WIDTH: source and destination router.
- `hdr_seq` in SEQ_NUM_WIDTH: sn for DATA, rn for ACK.
- `valid_ack_pkt_recv` out 1: an ACK is buffered.
- `rn_ack_pkt_recv` out SEQ_NUM_WIDTH: rn of the buffered ACK.
- `src_dfx_ack_pkt_recv` out DFX_WIDTH: source of the buffered ACK.
- `wait_ack_pkt_recv` in 1: the send side is ready to consume the ACK.
- `start_deliver_pkt` out 1: one-cycle pulse. Deliver the current DATA payload.
- `deliver_src_dfx` out DFX_WIDTH, `deliver_sn` out SEQ_NUM_WIDTH: tags of the delivered packet.
- `deliver_done` in 1: the sink has finished.
- `ack_req_valid` out 1, `ack_req_ready` in 1: ACK-transmit request handshake.
- `ack_req_dst_dfx` out DFX_WIDTH, `ack_req_rn` out SEQ_NUM_WIDTH: ACK fields.
- `dup_cnt`, `misroute_cnt` out CNT_WIDTH: saturating drop counters.

## Operation
FSM states: IDLE, CHECK_SN, DELIVER, SEND_ACK, all reset to IDLE.

**Header acceptance**
- `hdr_ready` = (state == IDLE) && !ack_buf_full. It is combinational from registers only.
- Misrouted header (`hdr_dst_dfx != my_dfx`), any type:
  - The header is dropped.
  - `misroute_cnt` increments, saturating at all-ones.
  - State stays IDLE.

**ACK path**
- An accepted ACK addressed to this router loads the 1-entry ACK buffer (rn, src). The FSM stays in IDLE.
- `valid_ack_pkt_recv` = ack_buf_full.
- The buffer clears on the clock edge where `valid_ack_pkt_recv && wait_ack_pkt_recv`.
- While the buffer is full, `hdr_ready` is 0. This backpressures all traffic, DATA included.

**DATA path**
- An accepted DATA header addressed to this router is registered (src, sn), then the FSM moves to CHECK_SN.
- CHECK_SN compares sn with `rn_expect[src]`:
  - Equal: go to DELIVER.
  - Not equal (duplicate): `dup_cnt` increments (saturating), then go to SEND_ACK.
- DELIVER:
  - `start_deliver_pkt` is high for only the first DELIVER cycle.
  - `deliver_src_dfx`/`deliver_sn` hold the registered values.
  - `deliver_done` is sampled in every DELIVER cycle.
  - On `deliver_done`, `rn_expect[src]` increments (wraps at 2^SEQ_NUM_WIDTH) and the FSM goes to SEND_ACK.
- SEND_ACK:
  - `ack_req_valid` = 1, `ack_req_dst_dfx` = src, `ack_req_rn` = `rn_expect[src]`, where `rn_expect[src]` is the already-updated value.
  - The outputs hold stable until `ack_req_ready`. On the handshake edge the FSM goes to IDLE.
- `rn_expect[*]` reset to 0.

**Reset values**: every output is 0, with `hdr_ready` = 1 once reset deasserts.

## Timing
- ACK: accepted at edge T. `valid_ack_pkt_recv` = 1 in cycle T+1. If `wait_ack_pkt_recv` = 1 in that cycle, valid = 0 in T+2 and `hdr_ready` returns to 1 in T+2.
- In-order DATA: accepted at edge T.
  - Cycle T+1: CHECK_SN.
  - Cycle T+2: `start_deliver_pkt` = 1.
  - `deliver_done` in cycle D: `ack_req_valid` = 1 from D+1.
  - The minimum accept-to-ack-request latency is 3 cycles (`deliver_done` in T+2).
- Duplicate DATA: `ack_req_valid` = 1 in T+2. `dup_cnt` updates in T+2.
- Back-to-back headers: the next header is accepted at the earliest in the cycle after the ACK handshake, because `hdr_ready` = 1 only in IDLE.
- rn wrap with SEQ_NUM_WIDTH=1 is 1 → 0.
- Counters hold at all-ones, e.g. 255 stays 255.
- `rst` asserted mid-operation, in any state: the FSM, buffer, table, counters and outputs clear immediately. No pending ACK request survives.

## Structure
- Shared package `router_pkg` holds:
  - `PKT_DATA`/`PKT_ACK` constants.
  - The `ROUTER0..3` ids.
  - The recv FSM state encoding, also shared with the bench.
- Sub-module `seq_table`: NR × SEQ_NUM_WIDTH register file.
  - One read port, indexed by the registered src.
  - One increment-write port, enabled on `deliver_done` in DELIVER.
  - Asynchronous reset to 0.

## Test plan
- Reset, then DATA src=1, sn=0, dst=my_dfx=0. Required:
  - `start_deliver_pkt` pulse with `deliver_sn`=0.
  - After `deliver_done`, an ACK request with dst=1, rn=1.
  - `rn_expect[1]`=1.
- Repeat DATA src=1, sn=0. Required:
  - No `start_deliver_pkt`.
  - `dup_cnt`=1.
  - ACK request rn=1.
- ACK rn=1, src=2 with `wait_ack_pkt_recv`=0 for 5 cycles. Required:
  - valid held and `hdr_ready`=0 throughout.
  - Raise wait: valid drops the next cycle and outputs read rn=1, src=2.
- DATA dst=3 with my_dfx=0. Required: no ACK request, `misroute_cnt`=1, and 300 such headers leave `misroute_cnt`=255.
- Hold `ack_req_ready`=0 for 10 cycles in SEND_ACK. Required: outputs stable and `hdr_ready`=0. Then assert `rst` mid-DELIVER in a second run: all outputs 0 and `rn_expect` cleared.
